gcd_operand_sequencer: RTL and testbench

Upstream feeder for the GCD controller/datapath. It accepts operand pairs on a valid/ready interface and buffers them in a small FIFO. It issues one pair at a time to the GCD core with a start/done handshake, and returns the result on a valid/ready output. Zero operands bypass the core, because the subtraction loop never terminates on them. A watchdog flags a core that never reports done.

---
 rtl/gcd_operand_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_gcd_operand_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_operand_sequencer.sv
// Operand feeder for the GCD core: buffers operand pairs in a small FIFO, issues them
// one at a time over a start/done handshake, bypasses zero operands, and times out a silent core.
module gcd_operand_sequencer #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             core_start,
  output logic [WIDTH-1:0] core_x,
  output logic [WIDTH-1:0] core_y,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_gcd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [1:0]       out_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [7:0]    TIMER_LAST = 8'(TIMEOUT - 1);

  // LOAD classifies the freshly popped operands; it keeps the pop and the
  // zero test in separate cycles so both register stages stay simple.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] mem_x [DEPTH];
  logic [WIDTH-1:0] mem_y [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_next;
  logic             push, pop;

  logic [WIDTH-1:0] op_x, op_y;
  logic [7:0]       timer;
  logic             timer_clr, timer_inc, load_core, set_result;
  logic [WIDTH-1:0] res_gcd;
  logic [1:0]       res_err;

  assign push = in_valid && in_ready;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr] <= in_x;
      mem_y[wr_ptr] <= in_y;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count    <= count_next;
      in_ready <= (count_next != FULL_COUNT);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    load_core  = 1'b0;
    set_result = 1'b0;
    res_gcd    = '0;
    res_err    = 2'b00;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (op_x == '0 && op_y == '0) begin
          set_result = 1'b1;
          res_err    = 2'b01;
          state_next = S_RESULT;
        end else if (op_x == '0) begin
          set_result = 1'b1;
          res_gcd    = op_y;
          state_next = S_RESULT;
        end else if (op_y == '0) begin
          set_result = 1'b1;
          res_gcd    = op_x;
          state_next = S_RESULT;
        end else begin
          load_core  = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_clr  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          set_result = 1'b1;
          res_gcd    = core_gcd;
          state_next = S_RESULT;
        end else if (timer == TIMER_LAST) begin
          set_result = 1'b1;
          res_err    = 2'b10;
          state_next = S_RESULT;
        end else begin
          timer_inc = 1'b1;
        end
      end
      S_RESULT: begin
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_x    <= '0;
      op_y    <= '0;
      core_x  <= '0;
      core_y  <= '0;
      timer   <= '0;
      out_gcd <= '0;
      out_err <= 2'b00;
    end else begin
      if (pop) begin
        op_x <= mem_x[rd_ptr];
        op_y <= mem_y[rd_ptr];
      end
      if (load_core) begin
        core_x <= op_x;
        core_y <= op_y;
      end
      if (timer_clr) begin
        timer <= '0;
      end else if (timer_inc) begin
        timer <= timer + 8'd1;
      end
      if (set_result) begin
        out_gcd <= res_gcd;
        out_err <= res_err;
      end
    end
  end

  assign core_start = (state == S_ISSUE);
  assign out_valid  = (state == S_RESULT);
  assign out_x      = op_x;
  assign out_y      = op_y;

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Directed and randomized checks of gcd_operand_sequencer against an arithmetic GCD model,
// with a behavioural GCD core responder and an in-order result scoreboard.
module tb_gcd_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [3:0] in_x, in_y;
  logic       core_start;
  logic [3:0] core_x, core_y;
  logic       core_done;
  logic [3:0] core_gcd;
  logic       out_valid, out_ready;
  logic [3:0] out_gcd, out_x, out_y;
  logic [1:0] out_err;

  logic       model_done = 1'b0;
  logic       poke_done  = 1'b0;
  logic [3:0] model_gcd  = '0;
  logic [3:0] poke_gcd   = '0;

  assign core_done = model_done | poke_done;
  assign core_gcd  = model_done ? model_gcd : poke_gcd;

  gcd_operand_sequencer #(.WIDTH(4), .DEPTH(2), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .core_start(core_start), .core_x(core_x), .core_y(core_y),
    .core_done(core_done), .core_gcd(core_gcd),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
    .out_x(out_x), .out_y(out_y), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x, y, gcd;
    logic [1:0] err;
  } exp_t;

  typedef struct {
    logic [3:0]  x, y;
    bit          hang;
    int unsigned dly;
  } issue_t;

  exp_t   exp_q[$];
  issue_t issue_q[$];
  int unsigned checks = 0, errors = 0, starts = 0, received = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] euclid(input logic [3:0] a, input logic [3:0] b);
    int unsigned p, q, t;
    p = a;
    q = b;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return 4'(p);
  endfunction

  function automatic exp_t ref_result(input logic [3:0] x, input logic [3:0] y, input bit hang);
    exp_t r;
    r.x = x;
    r.y = y;
    r.err = 2'b00;
    if (x == 0 && y == 0) begin
      r.gcd = 0; r.err = 2'b01;
    end else if (x == 0) begin
      r.gcd = y;
    end else if (y == 0) begin
      r.gcd = x;
    end else if (hang) begin
      r.gcd = 0; r.err = 2'b10;
    end else begin
      r.gcd = euclid(x, y);
    end
    return r;
  endfunction

  // Behavioural GCD core: answers each start after a per-pair delay, or never.
  initial begin
    issue_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && core_start === 1'b1) begin
        starts++;
        check("start_expected", issue_q.size() != 0, 1);
        if (issue_q.size() != 0) begin
          e = issue_q.pop_front();
          check("core_x", core_x, e.x);
          check("core_y", core_y, e.y);
          if (!e.hang) begin
            repeat (e.dly) @(negedge clk);
            model_gcd  = euclid(e.x, e.y);
            model_done = 1'b1;
            @(negedge clk);
            model_done = 1'b0;
          end
        end
      end
    end
  end

  // Result scoreboard: every accepted result must match the oldest outstanding pair.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        check("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_gcd", out_gcd, e.gcd);
          check("out_x", out_x, e.x);
          check("out_y", out_y, e.y);
          check("out_err", out_err, e.err);
          received++;
        end
      end
    end
  end

  task automatic push(input logic [3:0] x, input logic [3:0] y, input bit hang,
                      input int unsigned dly, input bit rnd_ready, output int unsigned waited);
    issue_t i;
    @(negedge clk);
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      waited++;
    end
    check("push_accepted", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(ref_result(x, y, hang));
    if (x != 0 && y != 0) begin
      i.x = x; i.y = y; i.hang = hang; i.dly = dly;
      issue_q.push_back(i);
    end
  endtask

  task automatic drain(input string tag);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w, n, s0, r0;
    logic [3:0] rx, ry;
    reset = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_x", core_x, 0);
    check("rst_core_y", core_y, 0);
    check("rst_out_gcd", out_gcd, 0);
    check("rst_out_x", out_x, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_err", out_err, 0);
    reset = 1'b1;

    // Core path: (12,8), done five cycles after start.
    s0 = starts;
    push(4'd12, 4'd8, 0, 5, 0, w);
    @(negedge clk); check("t1_start_lat0", core_start, 0);
    @(negedge clk); check("t1_start_lat1", core_start, 0);
    @(negedge clk); check("t1_start_lat2", core_start, 1);
    check("t1_core_x", core_x, 12);
    check("t1_core_y", core_y, 8);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (core_done !== 1'b1 && n < 100);
    check("t1_done_seen", core_done, 1);
    check("t1_valid_before", out_valid, 0);
    @(negedge clk);
    check("t1_valid_after", out_valid, 1);
    check("t1_gcd", out_gcd, 4);
    check("t1_x", out_x, 12);
    check("t1_y", out_y, 8);
    check("t1_err", out_err, 0);
    check("t1_one_start", starts - s0, 1);
    out_ready = 1'b1;
    drain("t1_drain");

    // Zero bypass.
    s0 = starts;
    push(4'd0, 4'd9, 0, 1, 0, w);
    @(negedge clk); check("t2_lat0", out_valid, 0);
    @(negedge clk); check("t2_lat1", out_valid, 0);
    @(negedge clk); check("t2_lat2", out_valid, 1);
    push(4'd0, 4'd0, 0, 1, 0, w);
    drain("t2_drain");
    check("t2_no_start", starts - s0, 0);

    // Capacity: three accepted while stalled, fourth waits.
    out_ready = 1'b0;
    push(4'd6, 4'd4, 0, 2, 0, w);  check("t3_acc0", w, 0);
    push(4'd15, 4'd5, 0, 2, 0, w); check("t3_acc1", w, 0);
    push(4'd9, 4'd3, 0, 2, 0, w);  check("t3_acc2", w, 0);
    repeat (5) begin
      @(negedge clk);
      check("t3_full", in_ready, 0);
    end
    out_ready = 1'b1;
    push(4'd7, 4'd7, 0, 2, 0, w);
    check("t3_fourth_waited", w > 0, 1);
    drain("t3_drain");

    // Timeout, then the queued pair proceeds normally.
    out_ready = 1'b0;
    s0 = starts;
    push(4'd13, 4'd11, 1, 0, 0, w);
    push(4'd10, 4'd4, 0, 3, 0, w);
    n = 0;
    while (core_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("t4_issue", core_start, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (out_valid !== 1'b1 && n < 200);
    check("t4_wait_cycles", n, 65);
    check("t4_gcd", out_gcd, 0);
    check("t4_err", out_err, 2);
    out_ready = 1'b1;
    drain("t4_drain");
    check("t4_starts", starts - s0, 2);

    // Reset during WAIT with one pair queued.
    push(4'd14, 4'd6, 1, 0, 0, w);
    push(4'd3, 4'd9, 0, 2, 0, w);
    n = 0;
    while (core_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_in_ready", in_ready, 1);
    check("t5_out_valid", out_valid, 0);
    check("t5_core_x", core_x, 0);
    check("t5_core_y", core_y, 0);
    check("t5_out_gcd", out_gcd, 0);
    check("t5_out_x", out_x, 0);
    check("t5_out_err", out_err, 0);
    exp_q.delete();
    issue_q.delete();
    s0 = starts;
    r0 = received;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_no_start", starts - s0, 0);
    check("t5_no_result", received - r0, 0);
    check("t5_idle_valid", out_valid, 0);

    // core_done outside WAIT is ignored.
    s0 = starts;
    poke_gcd = 4'd15;
    poke_done = 1'b1;
    @(negedge clk);
    poke_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t6_idle_poke", out_valid, 0);
    end
    out_ready = 1'b0;
    push(4'd9, 4'd6, 0, 3, 0, w);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("t6_result", out_valid, 1);
    poke_gcd = 4'd1;
    poke_done = 1'b1;
    @(negedge clk);
    poke_done = 1'b0;
    check("t6_held_gcd", out_gcd, 3);
    check("t6_held_valid", out_valid, 1);
    out_ready = 1'b1;
    drain("t6_drain0");
    push(4'd8, 4'd12, 0, 2, 0, w);
    drain("t6_drain1");
    check("t6_starts", starts - s0, 2);

    // Randomized traffic with output back-pressure.
    for (int k = 0; k < 40; k++) begin
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) rx = '0;
      if ($urandom_range(0, 4) == 0) ry = '0;
      push(rx, ry, 0, $urandom_range(1, 6), 1, w);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
